// File: rtl/writeback_stage_pkg.sv
// Shared LC-3b types for the write-back stage: result selector, condition codes
// and the registered MEM/WB bundle.
package writeback_stage_pkg;

  typedef enum logic [1:0] {WB_ALU, WB_WORD, WB_BYTE, WB_PC} lc3b_wbsel;

  typedef logic [2:0] lc3b_nzp;

  localparam lc3b_nzp NZP_Z = 3'b010;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        load_cc;
    lc3b_wbsel   wbsel;
    logic [2:0]  dest;
    logic [15:0] alu_out;
    logic [15:0] rdata;
    logic        addr_lsb;
    logic [15:0] pc;
  } memwb_t;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/writeback_stage_gencc.sv
// Condition-code generator: maps a 16-bit word to {n,z,p} with exactly one bit set.
// Shared with the branch-compare logic.
module writeback_stage_gencc
  import writeback_stage_pkg::*;
(
  input  logic [15:0] data_i,
  output lc3b_nzp     nzp_o
);

  logic is_zero;

  assign is_zero = (data_i == 16'h0000);
  assign nzp_o   = {data_i[15], is_zero, ~data_i[15] & ~is_zero};

endmodule

// File: rtl/writeback_stage.sv
// LC-3b write-back stage: MEM/WB register, result select, regfile write port,
// NZP update, forwarding tap and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int      CNT_WIDTH = 32,
  parameter lc3b_nzp RESET_NZP = NZP_Z
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 mem_valid,
  input  logic                 mem_regwrite,
  input  logic                 mem_load_cc,
  input  lc3b_wbsel            mem_wbsel,
  input  logic [2:0]           mem_dest,
  input  logic [15:0]          mem_alu_out,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_addr_lsb,
  input  logic [15:0]          mem_pc,
  output logic                 load_regfile,
  output logic [2:0]           write_register,
  output logic [15:0]          write_data,
  output lc3b_nzp              nzp,
  output logic                 fwd_valid,
  output logic [2:0]           fwd_dest,
  output logic [15:0]          fwd_data,
  output logic [CNT_WIDTH-1:0] retired
);

  memwb_t                 memwb_q;
  logic                   committed_q, committed_d;
  lc3b_nzp                nzp_q, nzp_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  logic                   commit;
  logic [15:0]            result;
  lc3b_nzp                result_nzp;

  always_comb begin
    result = memwb_q.alu_out;
    case (memwb_q.wbsel)
      WB_ALU:  result = memwb_q.alu_out;
      WB_WORD: result = memwb_q.rdata;
      WB_BYTE: result = memwb_q.addr_lsb ? sext8(memwb_q.rdata[15:8])
                                         : sext8(memwb_q.rdata[7:0]);
      WB_PC:   result = memwb_q.pc;
      default: result = memwb_q.alu_out;
    endcase
  end

  writeback_stage_gencc u_gencc (
    .data_i (result),
    .nzp_o  (result_nzp)
  );

  // The commit edge is the one edge the regfile latches this instruction; the
  // flag keeps a long stall from repeating the write, NZP update or count.
  assign commit = memwb_q.valid & ~committed_q;

  always_comb begin
    committed_d = committed_q;
    nzp_d       = nzp_q;
    retired_d   = retired_q;
    if (!stall)
      committed_d = 1'b0;
    else if (commit)
      committed_d = 1'b1;
    if (commit) begin
      retired_d = retired_q + CNT_WIDTH'(1);
      if (memwb_q.load_cc)
        nzp_d = result_nzp;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memwb_q     <= '0;
      committed_q <= 1'b0;
      nzp_q       <= RESET_NZP;
      retired_q   <= '0;
    end else begin
      if (!stall)
        memwb_q <= '{valid:    mem_valid,
                     regwrite: mem_regwrite,
                     load_cc:  mem_load_cc,
                     wbsel:    mem_wbsel,
                     dest:     mem_dest,
                     alu_out:  mem_alu_out,
                     rdata:    mem_rdata,
                     addr_lsb: mem_addr_lsb,
                     pc:       mem_pc};
      committed_q <= committed_d;
      nzp_q       <= nzp_d;
      retired_q   <= retired_d;
    end
  end

  assign load_regfile   = commit & memwb_q.regwrite;
  assign write_register = memwb_q.dest;
  assign write_data     = result;
  assign nzp            = nzp_q;
  // Stays up after commit so a reader arriving late still sees the value.
  assign fwd_valid      = memwb_q.valid & memwb_q.regwrite;
  assign fwd_dest       = memwb_q.dest;
  assign fwd_data       = result;
  assign retired        = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for single instructions plus
// hand sequences for stall, back-to-back, reset-mid-stall and counter wrap.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, stall;
  logic        mem_valid, mem_regwrite, mem_load_cc, mem_addr_lsb;
  lc3b_wbsel   mem_wbsel;
  logic [2:0]  mem_dest;
  logic [15:0] mem_alu_out, mem_rdata, mem_pc;

  logic        load_regfile, fwd_valid;
  logic [2:0]  write_register, fwd_dest;
  logic [15:0] write_data, fwd_data;
  lc3b_nzp     nzp;
  logic [31:0] retired;

  logic        n4_load, n4_fwd_valid;
  logic [2:0]  n4_wreg, n4_fwd_dest;
  logic [15:0] n4_wdata, n4_fwd_data;
  lc3b_nzp     n4_nzp;
  logic [3:0]  retired4;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_load_cc(mem_load_cc),
    .mem_wbsel(mem_wbsel), .mem_dest(mem_dest), .mem_alu_out(mem_alu_out),
    .mem_rdata(mem_rdata), .mem_addr_lsb(mem_addr_lsb), .mem_pc(mem_pc),
    .load_regfile(load_regfile), .write_register(write_register), .write_data(write_data),
    .nzp(nzp), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .retired(retired)
  );

  writeback_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_load_cc(mem_load_cc),
    .mem_wbsel(mem_wbsel), .mem_dest(mem_dest), .mem_alu_out(mem_alu_out),
    .mem_rdata(mem_rdata), .mem_addr_lsb(mem_addr_lsb), .mem_pc(mem_pc),
    .load_regfile(n4_load), .write_register(n4_wreg), .write_data(n4_wdata),
    .nzp(n4_nzp), .fwd_valid(n4_fwd_valid), .fwd_dest(n4_fwd_dest), .fwd_data(n4_fwd_data),
    .retired(retired4)
  );

  typedef struct {
    logic        v, rw, cc;
    lc3b_wbsel   wbsel;
    logic [2:0]  dest;
    logic [15:0] alu, rdata;
    logic        lsb;
    logic [15:0] pc;
    logic        exp_load, exp_fwd;
    logic [15:0] exp_data;
    logic [2:0]  exp_nzp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic cc, input lc3b_wbsel ws,
                       input logic [2:0] d, input logic [15:0] alu, input logic [15:0] rd,
                       input logic lsb, input logic [15:0] pc);
    mem_valid = v; mem_regwrite = rw; mem_load_cc = cc; mem_wbsel = ws;
    mem_dest = d; mem_alu_out = alu; mem_rdata = rd; mem_addr_lsb = lsb; mem_pc = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, WB_ALU, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          v    rw   cc   wbsel    dst   alu       rdata     lsb   pc        load fwd  data      nzp
    vecs[0] = '{1'b1,1'b1,1'b1,WB_ALU, 3'd3, 16'h8000,16'h0000,1'b0,16'h0000,1'b1,1'b1,16'h8000,3'b100};
    vecs[1] = '{1'b1,1'b1,1'b1,WB_BYTE,3'd2, 16'h0000,16'h807F,1'b0,16'h0000,1'b1,1'b1,16'h007F,3'b001};
    vecs[2] = '{1'b1,1'b1,1'b1,WB_BYTE,3'd2, 16'h0000,16'h807F,1'b1,16'h0000,1'b1,1'b1,16'hFF80,3'b100};
    vecs[3] = '{1'b1,1'b1,1'b0,WB_PC,  3'd7, 16'h0000,16'h0000,1'b0,16'h3002,1'b1,1'b1,16'h3002,3'b100};
    vecs[4] = '{1'b1,1'b1,1'b1,WB_WORD,3'd5, 16'h1111,16'h0000,1'b0,16'h0000,1'b1,1'b1,16'h0000,3'b010};
    vecs[5] = '{1'b1,1'b0,1'b0,WB_ALU, 3'd6, 16'h1234,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h1234,3'b010};
    vecs[6] = '{1'b0,1'b1,1'b1,WB_ALU, 3'd1, 16'h8001,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h8001,3'b010};
    vecs[7] = '{1'b1,1'b1,1'b1,WB_WORD,3'd4, 16'h0000,16'hFFFF,1'b0,16'h0000,1'b1,1'b1,16'hFFFF,3'b100};
    vecs[8] = '{1'b1,1'b1,1'b1,WB_ALU, 3'd0, 16'h7FFF,16'h0000,1'b0,16'h0000,1'b1,1'b1,16'h7FFF,3'b001};

    reset_n = 1'b0;
    stall   = 1'b0;
    bubble();
    step();
    step();
    check("reset_load", load_regfile, 1'b0);
    check("reset_fwd_valid", fwd_valid, 1'b0);
    check("reset_wreg", write_register, 3'd0);
    check("reset_wdata", write_data, 16'h0000);
    check("reset_nzp", nzp, 3'b010);
    check("reset_retired", retired, 32'd0);
    check("reset_retired4", retired4, 4'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].cc, vecs[i].wbsel, vecs[i].dest,
            vecs[i].alu, vecs[i].rdata, vecs[i].lsb, vecs[i].pc);
      step();
      check($sformatf("v%0d_load", i), load_regfile, vecs[i].exp_load);
      check($sformatf("v%0d_wreg", i), write_register, vecs[i].dest);
      check($sformatf("v%0d_wdata", i), write_data, vecs[i].exp_data);
      check($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].exp_fwd);
      check($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
      bubble();
      step();
      if (vecs[i].v) exp_ret++;
      check($sformatf("v%0d_nzp", i), nzp, vecs[i].exp_nzp);
      check($sformatf("v%0d_retired", i), retired, exp_ret);
      $display("vec %0d: dest=%0d data=%h nzp=%b retired=%0d", i, write_register, write_data, nzp, retired);
    end

    // ADD held under a 5-cycle stall: one write, one NZP update, one retire.
    drive(1'b1, 1'b1, 1'b1, WB_ALU, 3'd3, 16'h8000, 16'h0, 1'b0, 16'h0);
    step();
    check("stall_first_load", load_regfile, 1'b1);
    pulses = int'(load_regfile);
    stall = 1'b1;
    bubble();
    repeat (5) begin
      step();
      pulses += int'(load_regfile);
    end
    exp_ret++;
    check("stall_pulses", pulses, 1);
    check("stall_fwd_held", fwd_valid, 1'b1);
    check("stall_fwd_dest", fwd_dest, 3'd3);
    check("stall_nzp", nzp, 3'b100);
    check("stall_retired", retired, exp_ret);
    stall = 1'b0;
    step();
    check("stall_release_load", load_regfile, 1'b0);
    check("stall_release_retired", retired, exp_ret);
    $display("stall seq: pulses=%0d nzp=%b retired=%0d", pulses, nzp, retired);

    // Back-to-back ADD r=0 then ST.
    drive(1'b1, 1'b1, 1'b1, WB_ALU, 3'd1, 16'h0000, 16'h0, 1'b0, 16'h0);
    step();
    check("b2b_add_load", load_regfile, 1'b1);
    drive(1'b1, 1'b0, 1'b0, WB_ALU, 3'd2, 16'h5555, 16'h0, 1'b0, 16'h0);
    step();
    exp_ret++;
    check("b2b_nzp", nzp, 3'b010);
    check("b2b_st_load", load_regfile, 1'b0);
    check("b2b_st_fwd", fwd_valid, 1'b0);
    bubble();
    step();
    exp_ret++;
    check("b2b_retired", retired, exp_ret);
    check("b2b_nzp_after_st", nzp, 3'b010);
    $display("b2b seq: nzp=%b retired=%0d", nzp, retired);

    // Reset while a stalled, uncommitted ADD is held.
    drive(1'b1, 1'b1, 1'b1, WB_ALU, 3'd4, 16'h8001, 16'h0, 1'b0, 16'h0);
    step();
    check("rst_pre_load", load_regfile, 1'b1);
    stall = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    exp_ret = 0;
    check("rst_async_load", load_regfile, 1'b0);
    check("rst_async_fwd", fwd_valid, 1'b0);
    check("rst_async_wreg", write_register, 3'd0);
    check("rst_async_wdata", write_data, 16'h0000);
    check("rst_async_nzp", nzp, 3'b010);
    check("rst_async_retired", retired, 32'd0);
    step();
    reset_n = 1'b1;
    bubble();
    pulses = 0;
    repeat (4) begin
      step();
      pulses += int'(load_regfile);
    end
    stall = 1'b0;
    repeat (2) begin
      step();
      pulses += int'(load_regfile);
    end
    check("rst_no_write", pulses, 0);
    check("rst_nzp", nzp, 3'b010);
    check("rst_retired", retired, exp_ret);
    $display("reset seq: pulses=%0d nzp=%b retired=%0d", pulses, nzp, retired);

    // 17 retires: 32-bit counter reads 17, 4-bit counter wraps to 1.
    drive(1'b1, 1'b0, 1'b0, WB_ALU, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    repeat (17) step();
    bubble();
    step();
    exp_ret += 17;
    check("wrap_retired", retired, exp_ret);
    check("wrap_retired4", retired4, 4'(exp_ret));
    $display("wrap seq: retired=%0d retired4=%0d", retired, retired4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
